mem_access_unit: RTL and testbench

Load/store front end sitting directly upstream of the 256-word data memory in the MIPS_32 datapath. It accepts one byte, halfword or word access from the MEM stage and converts it into word-wide memory reads and writes. Sub-word stores are done as read-modify-write. Load data is sign- or zero-extended. The pipeline is stalled through `req_ready` while an access is in flight.

---
 rtl/mem_access_unit_if.sv | 33 +++
 rtl/mem_access_unit.sv | 169 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Request, response and data-memory signals of the load/store front end.
// The unit uses the slave modport; the pipeline/memory side uses master.
interface mem_access_unit_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [1:0]            req_size;
    logic                  req_signed;
    logic [31:0]           req_addr;
    logic [31:0]           req_wdata;
    logic                  resp_valid;
    logic [31:0]           resp_rdata;
    logic                  resp_misalign;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_read;
    logic                  mem_write;
    logic [31:0]           mem_wdata;
    logic [31:0]           mem_rdata;

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_misalign,
               mem_addr, mem_read, mem_write, mem_wdata
    );

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_misalign,
               mem_addr, mem_read, mem_write, mem_wdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store front end: turns byte/half/word accesses into word-wide memory
// reads and writes, with read-modify-write for sub-word stores.
//
// state  | meaning
// IDLE   | ready to accept a request
// LOAD   | memory read, extended lane registered into resp_rdata
// RMW_RD | memory read of the word a sub-word store will merge into
// WRITE  | memory write of the captured or merged word
// RESP   | one-cycle completion pulse
module mem_access_unit #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    mem_access_unit_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} stateT;

    stateT                 state;
    stateT                 nextState;

    logic                  capWrite;
    logic [1:0]            capSize;
    logic                  capSigned;
    logic [ADDR_WIDTH+1:0] capAddr;
    logic [31:0]           capWdata;
    logic [31:0]           mergeWord;
    logic [31:0]           respRdata;
    logic                  respMisalign;

    logic                  accept;
    logic                  reqMisaligned;
    logic [4:0]            laneShift;
    logic [31:0]           laneMask;
    logic [31:0]           shiftedRdata;
    logic [31:0]           loadValue;
    logic [31:0]           storeWord;

    logic                  readyNext;
    logic                  memReadNext;
    logic                  memWriteNext;
    logic                  respValidNext;
    logic [31:0]           memWdataNext;

    assign accept        = bus.req_valid && (state == IDLE);
    assign reqMisaligned = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                           (bus.req_size[1] && (bus.req_addr[1:0] != 2'b00));

    // Lane position and width of the captured access; words use the whole bus.
    always_comb begin
        laneShift = 5'd0;
        laneMask  = 32'hFFFF_FFFF;
        case (capSize)
            2'b00: begin
                laneShift = {capAddr[1:0], 3'b000};
                laneMask  = 32'h0000_00FF << laneShift;
            end
            2'b01: begin
                laneShift = {capAddr[1], 4'b0000};
                laneMask  = 32'h0000_FFFF << laneShift;
            end
            default: begin
                laneShift = 5'd0;
                laneMask  = 32'hFFFF_FFFF;
            end
        endcase
    end

    always_comb begin
        shiftedRdata = bus.mem_rdata >> laneShift;
        loadValue    = shiftedRdata;
        case (capSize)
            2'b00:   loadValue = {{24{capSigned & shiftedRdata[7]}}, shiftedRdata[7:0]};
            2'b01:   loadValue = {{16{capSigned & shiftedRdata[15]}}, shiftedRdata[15:0]};
            default: loadValue = shiftedRdata;
        endcase
    end

    assign storeWord = capSize[1] ? capWdata
                                  : ((mergeWord & ~laneMask) | ((capWdata << laneShift) & laneMask));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState     = state;
        readyNext     = 1'b0;
        memReadNext   = 1'b0;
        memWriteNext  = 1'b0;
        respValidNext = 1'b0;
        memWdataNext  = 32'h0;
        case (state)
            IDLE: begin
                readyNext = 1'b1;
                if (bus.req_valid) begin
                    if (reqMisaligned) begin
                        nextState = RESP;
                    end else if (!bus.req_write) begin
                        nextState = LOAD;
                    end else if (bus.req_size[1]) begin
                        nextState = WRITE;
                    end else begin
                        nextState = RMW_RD;
                    end
                end
            end
            LOAD: begin
                memReadNext = !reset;
                nextState   = RESP;
            end
            RMW_RD: begin
                memReadNext = !reset;
                nextState   = WRITE;
            end
            WRITE: begin
                memWriteNext = !reset;
                memWdataNext = storeWord;
                nextState    = RESP;
            end
            RESP: begin
                respValidNext = 1'b1;
                nextState     = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            capWrite     <= 1'b0;
            capSize      <= 2'b00;
            capSigned    <= 1'b0;
            capAddr      <= '0;
            capWdata     <= 32'h0;
            mergeWord    <= 32'h0;
            respRdata    <= 32'h0;
            respMisalign <= 1'b0;
        end else if (accept) begin
            capWrite     <= bus.req_write;
            capSize      <= bus.req_size;
            capSigned    <= bus.req_signed;
            capAddr      <= bus.req_addr[ADDR_WIDTH+1:0];
            capWdata     <= bus.req_wdata;
            respRdata    <= 32'h0;
            respMisalign <= reqMisaligned;
        end else begin
            if (state == LOAD) begin
                respRdata <= loadValue;
            end
            if (state == RMW_RD) begin
                mergeWord <= bus.mem_rdata;
            end
        end
    end

    assign bus.req_ready     = readyNext;
    assign bus.mem_read      = memReadNext;
    assign bus.mem_write     = memWriteNext && capWrite;
    assign bus.mem_wdata     = memWdataNext;
    assign bus.resp_valid    = respValidNext;
    assign bus.resp_rdata    = respRdata;
    assign bus.resp_misalign = respMisalign;
    assign bus.mem_addr      = capAddr[ADDR_WIDTH+1:2];
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed and randomized bench for mem_access_unit against a byte-level
// reference model of the load/store rules and a 256-word memory.
module tb_mem_access_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;

    mem_access_unit_if #(.ADDR_WIDTH(8)) bus ();

    mem_access_unit #(.ADDR_WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] mem    [256];
    logic [31:0] refMem [256];
    int          vectors     = 0;
    int          miscompares = 0;
    int          writeCount  = 0;
    int          respCount   = 0;
    logic [31:0] lastRdata   = 32'h0;

    assign bus.mem_rdata = mem[bus.mem_addr];

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= refMem[i];
        end else if (bus.mem_write) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
        end
    end

    always @(posedge clk) begin
        if (bus.mem_write) writeCount <= writeCount + 1;
        if (bus.resp_valid) respCount <= respCount + 1;
    end

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int nBytes(input logic [1:0] sz);
        return sz[1] ? 4 : ((sz == 2'b01) ? 2 : 1);
    endfunction

    function automatic int firstByte(input logic [1:0] sz, input logic [31:0] a);
        if (sz[1]) return 0;
        if (sz == 2'b01) return a[1] ? 2 : 0;
        return int'(a[1:0]);
    endfunction

    function automatic logic modelMis(input logic [1:0] sz, input logic [31:0] a);
        return (a % nBytes(sz)) != 0;
    endfunction

    function automatic logic [31:0] modelStore(input logic [31:0] old, input logic [1:0] sz,
                                               input logic [31:0] a, input logic [31:0] wd);
        logic [7:0] b [4];
        int n, base;
        n = nBytes(sz);
        base = firstByte(sz, a);
        for (int i = 0; i < 4; i++) b[i] = old[8*i +: 8];
        for (int i = 0; i < n; i++) b[base+i] = wd[8*i +: 8];
        return {b[3], b[2], b[1], b[0]};
    endfunction

    function automatic logic [31:0] modelLoad(input logic [31:0] old, input logic [1:0] sz,
                                              input logic sg, input logic [31:0] a);
        logic [31:0] v;
        int n, base;
        n = nBytes(sz);
        base = firstByte(sz, a);
        v = 32'h0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = old[8*(base+i) +: 8];
        if (sg && n < 4 && v[8*n-1]) begin
            for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
        end
        return v;
    endfunction

    task automatic driveReq(input logic w, input logic [1:0] sz, input logic sg,
                            input logic [31:0] a, input logic [31:0] wd);
        bus.req_valid  = 1'b1;
        bus.req_write  = w;
        bus.req_size   = sz;
        bus.req_signed = sg;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
    endtask

    task automatic scrambleReq();
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'($urandom_range(0, 1));
        bus.req_size   = 2'($urandom_range(0, 3));
        bus.req_signed = 1'($urandom_range(0, 1));
        bus.req_addr   = $urandom;
        bus.req_wdata  = $urandom;
    endtask

    task automatic doAccess(input logic w, input logic [1:0] sz, input logic sg,
                            input logic [31:0] a, input logic [31:0] wd, output logic [31:0] got);
        int          idx, lat;
        logic        mis, expRd, expWr, subStore;
        logic [31:0] expR, newW;
        idx      = int'(a[9:2]);
        mis      = modelMis(sz, a);
        subStore = w && !sz[1];
        expR     = (!mis && !w) ? modelLoad(refMem[idx], sz, sg, a) : 32'h0;
        newW     = modelStore(refMem[idx], sz, a, wd);
        lat      = mis ? 1 : (subStore ? 3 : 2);
        got      = 32'h0;
        @(negedge clk);
        chk("idle_ready", bus.req_ready, 1);
        chk("rdata_hold", bus.resp_rdata, lastRdata);
        driveReq(w, sz, sg, a, wd);
        @(posedge clk);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            if (k == 1) scrambleReq();
            expRd = !mis && (k == 1) && (!w || subStore);
            expWr = !mis && w && (k == lat - 1);
            chk("mem_read", bus.mem_read, expRd);
            chk("mem_write", bus.mem_write, expWr);
            chk("resp_valid", bus.resp_valid, k == lat);
            chk("busy_ready", bus.req_ready, 0);
            if (expRd || expWr) chk("mem_addr", bus.mem_addr, idx);
            if (expWr) chk("mem_wdata", bus.mem_wdata, newW);
            if (k == lat) begin
                chk("resp_rdata", bus.resp_rdata, expR);
                chk("resp_misalign", bus.resp_misalign, mis);
                got = bus.resp_rdata;
            end
        end
        if (!mis && w) refMem[idx] = newW;
        chk("mem_word", mem[idx], refMem[idx]);
        lastRdata = expR;
    endtask

    initial begin
        logic [31:0] got;
        int          wc0, rc0;
        for (int i = 0; i < 256; i++) refMem[i] = $urandom;
        refMem[3] = 32'h8899_AABB;
        scrambleReq();

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", bus.req_ready, 1);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_misalign", bus.resp_misalign, 0);
        chk("rst_mem_read", bus.mem_read, 0);
        chk("rst_mem_write", bus.mem_write, 0);
        chk("rst_rdata", bus.resp_rdata, 0);
        chk("rst_wdata", bus.mem_wdata, 0);
        chk("rst_addr", bus.mem_addr, 0);
        reset = 1'b0;

        doAccess(1'b0, 2'b10, 1'b0, 32'h0000_000C, 32'h0, got);
        chk("plan_word_load", got, 32'h8899_AABB);
        doAccess(1'b0, 2'b00, 1'b1, 32'h0000_000F, 32'h0, got);
        chk("plan_lb_signed", got, 32'hFFFF_FF88);
        doAccess(1'b0, 2'b00, 1'b0, 32'h0000_000F, 32'h0, got);
        chk("plan_lb_unsigned", got, 32'h0000_0088);
        doAccess(1'b0, 2'b01, 1'b1, 32'h0000_000C, 32'h0, got);
        chk("plan_lh_signed", got, 32'hFFFF_AABB);
        doAccess(1'b1, 2'b00, 1'b0, 32'h0000_000D, 32'hDEAD_BE12, got);
        doAccess(1'b0, 2'b10, 1'b0, 32'h0000_000C, 32'h0, got);
        chk("plan_rmw_result", got, 32'h8899_12BB);
        doAccess(1'b0, 2'b01, 1'b0, 32'h0000_000D, 32'h0, got);
        doAccess(1'b1, 2'b10, 1'b0, 32'h0000_000E, 32'h1234_5678, got);
        chk("plan_mis_mem", mem[3], 32'h8899_12BB);

        // req_valid held for six cycles on a byte store: accepts at T and T+4 only.
        @(negedge clk);
        wc0 = writeCount;
        driveReq(1'b1, 2'b00, 1'b0, 32'h0000_0021, 32'h0000_005A);
        @(posedge clk);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk("hold_busy_ready", bus.req_ready, 0);
        end
        chk("hold_resp", bus.resp_valid, 1);
        @(negedge clk);
        chk("hold_ready_t4", bus.req_ready, 1);
        chk("hold_one_write", writeCount - wc0, 1);
        @(negedge clk);
        chk("hold_second_rmw", bus.mem_read, 1);
        @(negedge clk);
        scrambleReq();
        chk("hold_second_write", bus.mem_write, 1);
        @(negedge clk);
        chk("hold_second_resp", bus.resp_valid, 1);
        chk("hold_two_writes", writeCount - wc0, 2);
        refMem[8] = modelStore(refMem[8], 2'b00, 32'h0000_0021, 32'h0000_005A);
        chk("hold_mem", mem[8], refMem[8]);
        lastRdata = 32'h0;

        // Reset during RMW_RD of a half store abandons the access.
        @(negedge clk);
        driveReq(1'b1, 2'b01, 1'b0, 32'h0000_0032, 32'h0000_BEEF);
        @(posedge clk);
        @(negedge clk);
        scrambleReq();
        chk("rstmid_rmw_read", bus.mem_read, 1);
        wc0 = writeCount;
        rc0 = respCount;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rstmid_ready", bus.req_ready, 1);
        chk("rstmid_no_resp", bus.resp_valid, 0);
        chk("rstmid_no_write", bus.mem_write, 0);
        repeat (3) @(negedge clk);
        chk("rstmid_write_count", writeCount - wc0, 0);
        chk("rstmid_resp_count", respCount - rc0, 0);
        chk("rstmid_mem", mem[12], refMem[12]);
        lastRdata = 32'h0;

        for (int n = 0; n < 60; n++) begin
            doAccess(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                     $urandom & 32'hFFFF_FC3F, $urandom, got);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
